pipe_chain: RTL and testbench

PIPE_CHAIN -- requirements
Module: pipe_chain

---
 rtl/pipe_chain.sv | 124 ++++++++++++
 tb/tb_pipe_chain.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_chain.sv
// pipe_chain: a linear chain of STAGES valid/data pipeline registers with per-stage
// stall and flush, ready/valid handshakes at both ends, and a saturating counter of
// entries destroyed by flush.
//
// Parameters
//   WIDTH    payload width in bits (>= 1)
//   STAGES   number of register stages (>= 1)
//   COLLAPSE 1: an empty stage keeps loading while downstream is held (bubbles squeeze out)
//            0: a hold propagates through every upstream stage
//
// Ports
//   clk, rst              clock; asynchronous active-high reset
//   in_valid/in_data      upstream payload; in_ready is high when stage 0 accepts it
//   stall[i], flush[i]    freeze stage i / kill stage i's next contents
//   out_valid/out_data    last stage; transfer happens on out_valid & out_ready
//   stage_valid/data      every stage's valid bit and data (stage i at [i*WIDTH +: WIDTH])
//   kill_count, kill_clr  saturating flush-kill counter and its synchronous clear
module pipe_chain #(
   parameter int unsigned WIDTH    = 16,
   parameter int unsigned STAGES   = 3,
   parameter bit          COLLAPSE = 1'b1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   input  logic [WIDTH-1:0]          in_data,
   output logic                      in_ready,
   input  logic [STAGES-1:0]         stall,
   input  logic [STAGES-1:0]         flush,
   input  logic                      out_ready,
   output logic                      out_valid,
   output logic [WIDTH-1:0]          out_data,
   output logic [STAGES-1:0]         stage_valid,
   output logic [STAGES*WIDTH-1:0]   stage_data,
   output logic [15:0]               kill_count,
   input  logic                      kill_clr
);

   logic [STAGES-1:0]             valid_q, valid_d;
   logic [STAGES-1:0][WIDTH-1:0]  data_q, data_d;
   logic [15:0]                   kill_count_q, kill_count_d;

   logic [STAGES-1:0]             hold;
   logic [STAGES-1:0]             valid_nf;  // next valid as if no flush were requested
   logic [STAGES-1:0]             kill;
   logic [31:0]                   kill_pop;
   logic [31:0]                   kill_sum;

   // Hold chain, evaluated from the output end back towards stage 0. Uses the
   // pre-flush valid bits so a flush never releases upstream backpressure.
   always_comb begin : p_hold
      logic h;
      hold = '0;
      h = stall[STAGES-1] | (valid_q[STAGES-1] & ~out_ready);
      hold[STAGES-1] = h;
      for (int i = int'(STAGES) - 2; i >= 0; i--) begin
         if (COLLAPSE) h = stall[i] | (h & valid_q[i]);
         else          h = stall[i] | h;
         hold[i] = h;
      end
   end

   assign in_ready = ~hold[0];

   // Load/hold per stage. Data moves whenever a stage is not held, valid or not;
   // a held upstream stage hands a bubble to the stage after it.
   always_comb begin
      valid_nf = '0;
      data_d   = data_q;
      if (hold[0]) begin
         valid_nf[0] = valid_q[0];
         data_d[0]   = data_q[0];
      end else begin
         valid_nf[0] = in_valid;
         data_d[0]   = in_data;
      end
      for (int i = 1; i < int'(STAGES); i++) begin
         if (hold[i]) begin
            valid_nf[i] = valid_q[i];
            data_d[i]   = data_q[i];
         end else begin
            valid_nf[i] = valid_q[i-1] & ~hold[i-1];
            data_d[i]   = data_q[i-1];
         end
      end
   end

   assign valid_d = valid_nf & ~flush;
   assign kill    = valid_nf & flush;

   always_comb begin
      kill_pop = '0;
      for (int i = 0; i < int'(STAGES); i++) begin
         kill_pop = kill_pop + 32'(kill[i]);
      end
      kill_sum = 32'(kill_count_q) + kill_pop;
      if (kill_clr) begin
         kill_count_d = '0;
      end else if (kill_sum > 32'h0000_FFFF) begin
         kill_count_d = 16'hFFFF;
      end else begin
         kill_count_d = kill_sum[15:0];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q      <= '0;
         data_q       <= '0;
         kill_count_q <= '0;
      end else begin
         valid_q      <= valid_d;
         data_q       <= data_d;
         kill_count_q <= kill_count_d;
      end
   end

   assign out_valid   = valid_q[STAGES-1];
   assign out_data    = data_q[STAGES-1];
   assign stage_valid = valid_q;
   assign stage_data  = data_q;
   assign kill_count  = kill_count_q;

endmodule

// File: tb/tb_pipe_chain.sv
// Bench for pipe_chain (WIDTH=16, STAGES=3). Two instances share the inputs: dut
// (COLLAPSE=1) is checked everywhere, dut_nc (COLLAPSE=0) in the no-collapse sequence.
module tb_pipe_chain;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [15:0] in_data;
   logic [2:0]  stall;
   logic [2:0]  flush;
   logic        out_ready;
   logic        kill_clr;

   logic        in_ready, out_valid;
   logic [15:0] out_data, kill_count;
   logic [2:0]  stage_valid;
   logic [47:0] stage_data;

   logic        nc_in_ready, nc_out_valid;
   logic [15:0] nc_out_data, nc_kill_count;
   logic [2:0]  nc_stage_valid;
   logic [47:0] nc_stage_data;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   pipe_chain #(.WIDTH(16), .STAGES(3), .COLLAPSE(1'b1)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .stall(stall), .flush(flush), .out_ready(out_ready), .out_valid(out_valid),
      .out_data(out_data), .stage_valid(stage_valid), .stage_data(stage_data),
      .kill_count(kill_count), .kill_clr(kill_clr)
   );

   pipe_chain #(.WIDTH(16), .STAGES(3), .COLLAPSE(1'b0)) dut_nc (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(nc_in_ready),
      .stall(stall), .flush(flush), .out_ready(out_ready), .out_valid(nc_out_valid),
      .out_data(nc_out_data), .stage_valid(nc_stage_valid), .stage_data(nc_stage_data),
      .kill_count(nc_kill_count), .kill_clr(kill_clr)
   );

   typedef struct {
      logic        iv;
      logic [15:0] id;
      logic [2:0]  st;
      logic [2:0]  fl;
      logic        ordy;
      logic        kclr;
      logic        exp_rdy;
      logic        exp_ov;
      logic [15:0] exp_od;
      logic [2:0]  exp_sv;
      logic [15:0] exp_kc;
   } vec_t;

   vec_t tbl[14];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic iv, input logic [15:0] id, input logic [2:0] st,
                        input logic [2:0] fl, input logic ordy, input logic kclr);
      in_valid  = iv;
      in_data   = id;
      stall     = st;
      flush     = fl;
      out_ready = ordy;
      kill_clr  = kclr;
   endtask

   // Advance to 1 time unit after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      drive(1'b0, 16'h0, 3'b000, 3'b000, 1'b1, 1'b0);
      rst = 1'b1;
      #2;
      rst = 1'b0;
      #1;
   endtask

   initial begin
      //                iv   id        st      fl      ordy kclr rdy  ov   od        sv      kc
      tbl[0]  = '{1'b1, 16'h0001, 3'b000, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 3'b001, 16'd0};
      tbl[1]  = '{1'b1, 16'h0002, 3'b000, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 3'b011, 16'd0};
      tbl[2]  = '{1'b1, 16'h0003, 3'b000, 3'b000, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0001, 3'b111, 16'd0};
      tbl[3]  = '{1'b0, 16'h0000, 3'b000, 3'b000, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0002, 3'b110, 16'd0};
      tbl[4]  = '{1'b0, 16'h0000, 3'b000, 3'b000, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0003, 3'b100, 16'd0};
      tbl[5]  = '{1'b0, 16'h0000, 3'b000, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 3'b000, 16'd0};
      tbl[6]  = '{1'b1, 16'h0011, 3'b000, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 3'b001, 16'd0};
      tbl[7]  = '{1'b1, 16'h0022, 3'b000, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 3'b011, 16'd0};
      tbl[8]  = '{1'b1, 16'h0033, 3'b000, 3'b000, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0011, 3'b111, 16'd0};
      tbl[9]  = '{1'b1, 16'h0044, 3'b000, 3'b111, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0022, 3'b000, 16'd3};
      tbl[10] = '{1'b1, 16'h0055, 3'b000, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0033, 3'b001, 16'd3};
      tbl[11] = '{1'b1, 16'h0066, 3'b000, 3'b001, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0044, 3'b010, 16'd0};
      tbl[12] = '{1'b0, 16'h0000, 3'b000, 3'b000, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0055, 3'b100, 16'd0};
      tbl[13] = '{1'b0, 16'h0000, 3'b000, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0066, 3'b000, 16'd0};

      // Reset state
      drive(1'b0, 16'h0, 3'b000, 3'b000, 1'b1, 1'b0);
      rst = 1'b1;
      #12;
      check("rst_sv", 64'(stage_valid), 64'h0);
      check("rst_sd", 64'(stage_data), 64'h0);
      check("rst_kc", 64'(kill_count), 64'h0);
      check("rst_ov", 64'(out_valid), 64'h0);
      @(negedge clk);
      rst = 1'b0;

      // Stream and flush-count vectors
      for (int i = 0; i < 14; i++) begin
         drive(tbl[i].iv, tbl[i].id, tbl[i].st, tbl[i].fl, tbl[i].ordy, tbl[i].kclr);
         #2;
         check($sformatf("v%0d_rdy", i), 64'(in_ready), 64'(tbl[i].exp_rdy));
         step();
         check($sformatf("v%0d_sv", i), 64'(stage_valid), 64'(tbl[i].exp_sv));
         check($sformatf("v%0d_ov", i), 64'(out_valid), 64'(tbl[i].exp_ov));
         check($sformatf("v%0d_od", i), 64'(out_data), 64'(tbl[i].exp_od));
         check($sformatf("v%0d_kc", i), 64'(kill_count), 64'(tbl[i].exp_kc));
      end

      // Backpressure: collapse vs no-collapse
      do_reset();
      drive(1'b1, 16'hA000, 3'b000, 3'b000, 1'b1, 1'b0);
      step();
      drive(1'b0, 16'h0000, 3'b000, 3'b000, 1'b1, 1'b0);
      step();
      step();
      check("bp_fill_sv", 64'(stage_valid), 64'h4);
      check("bp_fill_sd", 64'(stage_data), {16'h0, 16'hA000, 16'h0000, 16'h0000});
      check("bp_fill_nc_sv", 64'(nc_stage_valid), 64'h4);
      drive(1'b1, 16'hB000, 3'b000, 3'b000, 1'b0, 1'b0);
      #1;
      check("bp_rdy_b", 64'(in_ready), 64'h1);
      check("nc_rdy_b", 64'(nc_in_ready), 64'h0);
      step();
      check("bp_b_sv", 64'(stage_valid), 64'h5);
      check("bp_b_sd", 64'(stage_data), {16'h0, 16'hA000, 16'h0000, 16'hB000});
      check("nc_b_sv", 64'(nc_stage_valid), 64'h4);
      check("nc_b_sd", 64'(nc_stage_data), {16'h0, 16'hA000, 16'h0000, 16'h0000});
      drive(1'b1, 16'hC000, 3'b000, 3'b000, 1'b0, 1'b0);
      #1;
      check("bp_rdy_c", 64'(in_ready), 64'h1);
      step();
      check("bp_c_sv", 64'(stage_valid), 64'h7);
      check("bp_c_sd", 64'(stage_data), {16'h0, 16'hA000, 16'hB000, 16'hC000});
      drive(1'b1, 16'hD000, 3'b000, 3'b000, 1'b0, 1'b0);
      #1;
      check("bp_rdy_d", 64'(in_ready), 64'h0);
      step();
      check("bp_d_sv", 64'(stage_valid), 64'h7);
      check("bp_d_sd", 64'(stage_data), {16'h0, 16'hA000, 16'hB000, 16'hC000});
      check("nc_d_sd", 64'(nc_stage_data), {16'h0, 16'hA000, 16'h0000, 16'h0000});
      drive(1'b0, 16'h0000, 3'b000, 3'b000, 1'b1, 1'b0);
      step();
      check("bp_drain_sv", 64'(stage_valid), 64'h6);
      check("bp_drain_od", 64'(out_data), 64'hB000);

      // Stall bubble, then stall+flush on the same stage
      do_reset();
      drive(1'b1, 16'h0033, 3'b000, 3'b000, 1'b1, 1'b0);
      step();
      drive(1'b1, 16'h0022, 3'b000, 3'b000, 1'b1, 1'b0);
      step();
      drive(1'b1, 16'h0011, 3'b000, 3'b000, 1'b1, 1'b0);
      step();
      check("sb_full_sd", 64'(stage_data), {16'h0, 16'h0033, 16'h0022, 16'h0011});
      drive(1'b1, 16'h0044, 3'b010, 3'b000, 1'b1, 1'b0);
      #1;
      check("sb_rdy", 64'(in_ready), 64'h0);
      step();
      check("sb_sv", 64'(stage_valid), 64'h3);
      check("sb_sd", 64'(stage_data), {16'h0, 16'h0022, 16'h0022, 16'h0011});
      drive(1'b0, 16'h0000, 3'b000, 3'b000, 1'b1, 1'b0);
      #1;
      check("sb_rdy_after", 64'(in_ready), 64'h1);
      step();
      check("sb_after_sv", 64'(stage_valid), 64'h6);
      check("sb_after_sd", 64'(stage_data), {16'h0, 16'h0022, 16'h0011, 16'h0000});
      drive(1'b0, 16'h0000, 3'b010, 3'b010, 1'b1, 1'b0);
      step();
      check("sf_sv", 64'(stage_valid), 64'h0);
      check("sf_sd", 64'(stage_data), {16'h0, 16'h0011, 16'h0011, 16'h0000});
      check("sf_kc", 64'(kill_count), 64'h1);

      // Saturation: one kill per cycle up to 0xFFFE, then two more
      drive(1'b0, 16'h0000, 3'b000, 3'b000, 1'b1, 1'b1);
      step();
      check("sat_clr", 64'(kill_count), 64'h0);
      drive(1'b1, 16'h1234, 3'b000, 3'b001, 1'b1, 1'b0);
      repeat (65534) step();
      check("sat_fffe", 64'(kill_count), 64'hFFFE);
      check("sat_fffe_sv", 64'(stage_valid), 64'h0);
      drive(1'b1, 16'h1234, 3'b000, 3'b000, 1'b1, 1'b0);
      step();
      step();
      check("sat_fill_sv", 64'(stage_valid), 64'h3);
      drive(1'b0, 16'h0000, 3'b000, 3'b110, 1'b1, 1'b0);
      step();
      check("sat_ffff", 64'(kill_count), 64'hFFFF);
      check("sat_sv", 64'(stage_valid), 64'h0);
      drive(1'b1, 16'h0000, 3'b000, 3'b001, 1'b1, 1'b0);
      step();
      check("sat_stay", 64'(kill_count), 64'hFFFF);

      // Asynchronous reset mid-cycle with entries in flight
      drive(1'b1, 16'h5555, 3'b000, 3'b000, 1'b1, 1'b0);
      step();
      step();
      check("ar_pre_sv", 64'(stage_valid), 64'h3);
      #2;
      rst = 1'b1;
      #1;
      check("ar_sv", 64'(stage_valid), 64'h0);
      check("ar_sd", 64'(stage_data), 64'h0);
      check("ar_kc", 64'(kill_count), 64'h0);
      check("ar_ov", 64'(out_valid), 64'h0);
      check("ar_od", 64'(out_data), 64'h0);
      step();
      check("ar_edge_sv", 64'(stage_valid), 64'h0);
      #2;
      rst = 1'b0;
      drive(1'b1, 16'h0BEE, 3'b000, 3'b000, 1'b1, 1'b0);
      #1;
      check("ar_rdy", 64'(in_ready), 64'h1);
      step();
      drive(1'b0, 16'h0000, 3'b000, 3'b000, 1'b1, 1'b0);
      step();
      check("ar_lat2_ov", 64'(out_valid), 64'h0);
      step();
      check("ar_lat3_ov", 64'(out_valid), 64'h1);
      check("ar_lat3_od", 64'(out_data), 64'h0BEE);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
